// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: registered one-cycle request, response strobe with data.
interface fetch_stage_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_rvalid;
  logic [INST_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register: owns the PC, keeps one imem request in flight,
// absorbs stalls and discards wrong-path responses. Define FETCH_PERF_CNT_EN for flush/stall counters.
module fetch_stage #(
  parameter int unsigned           PC_WIDTH   = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pc_sel,
  input  logic                  IF_flush,
  input  logic [PC_WIDTH-1:0]   br_target,
  input  logic                  stall,
  fetch_stage_if.master         imem,
  output logic                  if_id_valid,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           flush_cnt,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  req_q, req_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   id_pc_q, id_pc_d;
  logic [INST_WIDTH-1:0] id_inst_q, id_inst_d;
  logic [INST_WIDTH-1:0] hold_q, hold_d;

  logic                  rvalid;
  logic [PC_WIDTH-1:0]   pc_inc;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  issue_en;
  logic                  load_en;
  logic [INST_WIDTH-1:0] load_inst;
  logic                  br_target_unused;

  assign rvalid           = imem.imem_rvalid;
  assign pc_inc           = pc_q + PC_WIDTH'(4);
  assign redirect_pc      = {br_target[PC_WIDTH-1:2], 2'b00};
  assign br_target_unused = ^br_target[1:0];

  // Every issued request goes to the next PC, so pc_d doubles as the request address.
  // NOTE: each signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    issue_en  = 1'b0;
    load_en   = 1'b0;
    load_inst = imem.imem_rdata;

    if (pc_sel) pc_d = redirect_pc;

    unique case (state_q)
      S_IDLE: issue_en = 1'b1;
      S_WAIT: begin
        if (rvalid) begin
          if (pc_sel) begin
            issue_en = 1'b1;
          end else if (stall) begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end else begin
            load_en  = 1'b1;
            pc_d     = pc_inc;
            issue_en = 1'b1;
          end
        end else if (pc_sel) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (pc_sel) begin
          issue_en = 1'b1;
        end else if (!stall) begin
          load_en   = 1'b1;
          load_inst = hold_q;
          pc_d      = pc_inc;
          issue_en  = 1'b1;
        end
      end
      S_DROP: begin
        // The wrong-path response retires the outstanding slot; refetch at the latest target.
        if (rvalid) issue_en = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue_en) state_d = S_WAIT;
    req_d  = issue_en;
    addr_d = issue_en ? pc_d : addr_q;
  end

  always_comb begin
    valid_d   = valid_q;
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    if (load_en && !IF_flush) begin
      valid_d   = 1'b1;
      id_pc_d   = pc_q;
      id_inst_d = load_inst;
    end else if (IF_flush || !stall) begin
      valid_d   = 1'b0;
      id_inst_d = NOP_INST;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      id_pc_q   <= '0;
      id_inst_q <= NOP_INST;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  // NOTE: hold_q is written on every entry to HOLD and read only there, so it carries no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_id_valid    = valid_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_inst     = id_inst_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (IF_flush && valid_q && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random stall/redirect
// traffic, all compared every cycle against a flag-based reference model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam int unsigned PW  = 32;
  localparam int unsigned IW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pc_sel = 1'b0;
  logic        IF_flush = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;
`endif

  fetch_stage_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) imem_bus ();

  fetch_stage #(
    .PC_WIDTH(PW), .INST_WIDTH(IW), .RESET_PC(RPC), .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pc_sel(pc_sel),
    .IF_flush(IF_flush),
    .br_target(br_target),
    .stall(stall),
    .imem(imem_bus),
    .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc),
    .if_id_inst(if_id_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .flush_cnt(flush_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: PC, "request outstanding", "outstanding response is wrong-path",
  // "a response is parked", plus the IF/ID contents and the request expected this cycle.
  logic [31:0] m_pc, m_hold, m_id_pc, m_id_inst, m_addr;
  logic        m_busy, m_drop, m_have_hold, m_valid, m_req;
  int unsigned m_flush_cnt, m_stall_cnt;

  // Memory responder: one request at a time, answers 1..lat_max cycles after the request.
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC; m_hold = '0; m_id_pc = '0; m_id_inst = NOP; m_addr = '0;
    m_busy = 1'b0; m_drop = 1'b0; m_have_hold = 1'b0; m_valid = 1'b0; m_req = 1'b0;
    m_flush_cnt = 0; m_stall_cnt = 0;
    mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0;
  endtask

  task automatic model_step(input logic sel, input logic flush, input logic [31:0] tgt,
                            input logic stl, input logic rv, input logic [31:0] rd);
    logic        issue, load;
    logic [31:0] ld_pc, ld_inst;
    issue = 1'b0; load = 1'b0; ld_pc = m_pc; ld_inst = rd;
    if (flush && m_valid) m_flush_cnt++;
    if (stl) m_stall_cnt++;
    if (!m_busy) begin
      if (sel) begin
        m_pc = tgt & ~32'h3; m_have_hold = 1'b0; issue = 1'b1;
      end else if (m_have_hold) begin
        if (!stl) begin
          load = 1'b1; ld_inst = m_hold; m_pc = m_pc + 32'd4; m_have_hold = 1'b0; issue = 1'b1;
        end
      end else begin
        issue = 1'b1;
      end
    end else if (rv) begin
      m_busy = 1'b0;
      if (sel) begin
        m_pc = tgt & ~32'h3; issue = 1'b1;
      end else if (m_drop) begin
        issue = 1'b1;
      end else if (stl) begin
        m_have_hold = 1'b1; m_hold = rd;
      end else begin
        load = 1'b1; m_pc = m_pc + 32'd4; issue = 1'b1;
      end
      m_drop = 1'b0;
    end else if (sel) begin
      m_pc = tgt & ~32'h3; m_drop = 1'b1;
    end
    m_req = issue;
    if (issue) begin
      m_busy = 1'b1; m_addr = m_pc;
    end
    if (load && !flush) begin
      m_valid = 1'b1; m_id_pc = ld_pc; m_id_inst = ld_inst;
    end else if (flush || !stl) begin
      m_valid = 1'b0; m_id_inst = NOP;
    end
  endtask

  task automatic step(input logic sel, input logic flush, input logic [31:0] tgt, input logic stl);
    logic        rv;
    logic [31:0] rd;
    rv = mem_busy && (mem_cnt == 0);
    rd = mem_word(mem_addr);
    pc_sel = sel; IF_flush = flush; br_target = tgt; stall = stl;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rv ? rd : $urandom;
    model_step(sel, flush, tgt, stl, rv, rd);
    @(posedge clk); #1;
    chk("req", {31'd0, imem_bus.imem_req}, {31'd0, m_req});
    if (m_req) chk("addr", imem_bus.imem_addr, m_addr);
    chk("valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("id_pc", if_id_pc, m_id_pc);
    chk("id_inst", if_id_inst, m_id_inst);
    if (mem_busy) begin
      if (rv) mem_busy = 1'b0;
      else mem_cnt--;
    end
    if (imem_bus.imem_req === 1'b1) begin
      mem_busy = 1'b1; mem_addr = imem_bus.imem_addr; mem_cnt = $urandom_range(1, lat_max);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0; pc_sel = 1'b0; IF_flush = 1'b0; stall = 1'b0;
    imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("rst_addr", imem_bus.imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_inst", if_id_inst, NOP);
    reset_n = 1'b1;
  endtask

  // Steps idle traffic until the next request appears (bounded), then checks its address.
  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0, 32'd0, 1'b0);
      n++;
    end while ((imem_bus.imem_req !== 1'b1) && (n < 20));
    chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_bus.imem_addr, exp_addr);
  endtask

  initial begin
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = '0;
    model_reset();

    // Reset, then back-to-back fetches with a one-cycle memory.
    do_reset(2);
    wait_req(32'h0, "t1_a0");
    wait_req(32'h4, "t1_a4");
    chk("t1_id_pc", if_id_pc, 32'h0);
    chk("t1_id_inst", if_id_inst, mem_word(32'h0));
    wait_req(32'h8, "t1_a8");
    chk("t1_id_pc4", if_id_pc, 32'h4);

    // Stall across the 0x8 response: 0x4 held, 0x8 appears once stall drops.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("t2_hold_pc", if_id_pc, 32'h4);
    chk("t2_hold_valid", {31'd0, if_id_valid}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("t2_pc8", if_id_pc, 32'h8);
    chk("t2_inst8", if_id_inst, mem_word(32'h8));
    chk("t2_next_addr", imem_bus.imem_addr, 32'hC);

    // Redirect with the 0xC request outstanding: its response is discarded.
    step(1'b1, 1'b1, 32'h103, 1'b0);
    chk("t3_valid", {31'd0, if_id_valid}, 32'd0);
    wait_req(32'h100, "t3_tgt");
    chk("t3_inst", if_id_inst, NOP);

    // Redirect in the same cycle as the response.
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b0);
    chk("t4_req", {31'd0, imem_bus.imem_req}, 32'd1);
    chk("t4_addr", imem_bus.imem_addr, 32'h200);
    chk("t4_inst", if_id_inst, NOP);

    // PC wrap at the top of the address space (target low bits masked).
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
    chk("t5_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    wait_req(32'h0, "t5_wrap");
    chk("t5_id_pc", if_id_pc, 32'hFFFF_FFFC);

    // Reset while a response is parked.
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    do_reset(1);
    wait_req(RPC, "t6_first");

    // Random traffic with variable memory latency.
    lat_max = 3;
    for (int i = 0; i < 600; i++) begin
      logic        sel;
      logic        stl;
      logic [31:0] tgt;
      if (i == 300) do_reset(2);
      sel = ($urandom_range(0, 15) == 0);
      stl = ($urandom_range(0, 3) == 0);
      tgt = $urandom;
      step(sel, sel, tgt, stl);
    end

`ifdef FETCH_PERF_CNT_EN
    chk("flush_cnt", flush_cnt, m_flush_cnt);
    chk("stall_cnt", stall_cnt, m_stall_cnt);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
